// File: rtl/gray_decoder.sv
// rtl/gray_decoder.sv - Gray-to-binary sampler with step/wrap tracking and illegal-transition detection
module gray_decoder #(
    parameter int W  = 3,
    parameter int CW = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          En,
    input  logic [W-1:0]  GrayIn,
    output logic [W-1:0]  Output,
    output logic          Step,
    output logic          Dir,
    output logic [CW-1:0] Wraps,
    output logic          Overflow,
    output logic          Error,
    output logic          Locked
);

    typedef enum logic [1:0] {
        S_UNLOCKED = 2'd0,
        S_TRACK    = 2'd1,
        S_FAULT    = 2'd2
    } state_t;

    localparam logic [W-1:0] MAX_B = {W{1'b1}};

    state_t        state_q, state_d;
    logic [W-1:0]  out_q, out_d;
    logic          step_q, step_d;
    logic          dir_q, dir_d;
    logic [CW-1:0] wraps_q, wraps_d;
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;
    logic          locked_q, locked_d;

    logic [W-1:0]  nb;
    logic [W-1:0]  delta;
    logic          is_up;
    logic          is_dn;

    always_comb begin
        nb        = '0;
        nb[W-1]   = GrayIn[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            nb[i] = nb[i+1] ^ GrayIn[i];
        end
    end

    // Output always holds the last accepted binary value, so it doubles as pb.
    assign delta = nb - out_q;
    assign is_up = (delta == {{(W-1){1'b0}}, 1'b1});
    assign is_dn = (delta == MAX_B);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_UNLOCKED;
            out_q    <= '0;
            step_q   <= 1'b0;
            dir_q    <= 1'b0;
            wraps_q  <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            wraps_q  <= wraps_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            locked_q <= locked_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        step_d   = 1'b0;
        dir_d    = dir_q;
        wraps_d  = wraps_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        locked_d = locked_q;
        case (state_q)
            S_UNLOCKED: begin
                if (En) begin
                    out_d    = nb;
                    locked_d = 1'b1;
                    state_d  = S_TRACK;
                end
            end
            S_TRACK: begin
                if (En && (delta != '0)) begin
                    if (is_up) begin
                        out_d  = nb;
                        step_d = 1'b1;
                        dir_d  = 1'b1;
                        if (out_q == MAX_B) begin
                            wraps_d = wraps_q + 1'b1;
                            ovf_d   = 1'b1;
                        end
                    end else if (is_dn) begin
                        out_d  = nb;
                        step_d = 1'b1;
                        dir_d  = 1'b0;
                        if (out_q == '0) begin
                            wraps_d = wraps_q - 1'b1;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_FAULT;
                    end
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_UNLOCKED;
            end
        endcase
    end

    always_comb begin
        Output   = out_q;
        Step     = step_q;
        Dir      = dir_q;
        Wraps    = wraps_q;
        Overflow = ovf_q;
        Error    = err_q;
        Locked   = locked_q;
    end

endmodule

// File: tb/tb_gray_decoder.sv
// tb/tb_gray_decoder.sv - randomized self-checking bench for gray_decoder against a table-based model
module tb_gray_decoder;

    localparam int W  = 3;
    localparam int CW = 4;
    localparam int M  = 1 << W;

    logic          clk;
    logic          reset;
    logic          en;
    logic [W-1:0]  gray_in;
    logic [W-1:0]  out_w;
    logic          step_w;
    logic          dir_w;
    logic [CW-1:0] wraps_w;
    logic          ovf_w;
    logic          err_w;
    logic          locked_w;

    int n_checks;
    int n_pass;

    gray_decoder #(.W(W), .CW(CW)) dut (
        .Clk      (clk),
        .Reset    (reset),
        .En       (en),
        .GrayIn   (gray_in),
        .Output   (out_w),
        .Step     (step_w),
        .Dir      (dir_w),
        .Wraps    (wraps_w),
        .Overflow (ovf_w),
        .Error    (err_w),
        .Locked   (locked_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  m_out;
    bit  m_step;
    bit  m_dir;
    int  m_wraps;
    bit  m_ovf;
    bit  m_err;
    bit  m_locked;

    function automatic int gray_of(input int b);
        return (b ^ (b >> 1)) % M;
    endfunction

    function automatic int bin_of(input int g);
        for (int b = 0; b < M; b++) begin
            if (gray_of(b) == g) return b;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit e, input int g);
        int nb;
        int d;
        if (rst) begin
            m_out = 0; m_step = 0; m_dir = 0; m_wraps = 0;
            m_ovf = 0; m_err = 0; m_locked = 0;
            return;
        end
        m_step = 0;
        if (!e) return;
        nb = bin_of(g);
        if (!m_locked) begin
            m_locked = 1;
            m_out    = nb;
        end else if (!m_err) begin
            d = ((nb - m_out) % M + M) % M;
            if (d == 0) begin
            end else if (d == 1) begin
                if (m_out == M - 1) begin
                    m_wraps++;
                    m_ovf = 1;
                end
                m_out = nb; m_step = 1; m_dir = 1;
            end else if (d == M - 1) begin
                if (m_out == 0) m_wraps--;
                m_out = nb; m_step = 1; m_dir = 0;
            end else begin
                m_err = 1;
            end
        end
    endtask

    task automatic check_all();
        check("output",   int'(out_w),    m_out);
        check("step",     int'(step_w),   int'(m_step));
        check("dir",      int'(dir_w),    int'(m_dir));
        check("wraps",    int'(wraps_w),  m_wraps & ((1 << CW) - 1));
        check("overflow", int'(ovf_w),    int'(m_ovf));
        check("error",    int'(err_w),    int'(m_err));
        check("locked",   int'(locked_w), int'(m_locked));
    endtask

    task automatic cycle(input bit rst, input bit e, input int g);
        reset   = rst;
        en      = e;
        gray_in = g[W-1:0];
        @(posedge clk);
        model_step(rst, e, g);
        #1;
        check_all();
    endtask

    initial begin
        int g;
        int sel;
        n_checks = 0;
        n_pass   = 0;
        reset = 1'b1; en = 1'b0; gray_in = '0;
        model_step(1, 0, 0);

        cycle(1, 0, 0);
        check("reset_locked", int'(locked_w), 0);

        // full upward sweep, then wrap to 0 and one more step
        for (int b = 0; b < M; b++) cycle(0, 1, gray_of(b));
        check("sweep_out7", int'(out_w), 7);
        cycle(0, 1, gray_of(0));
        check("wrap_up_wraps", int'(wraps_w), 1);
        check("wrap_up_ovf", int'(ovf_w), 1);
        cycle(0, 1, gray_of(1));
        check("ovf_sticky", int'(ovf_w), 1);

        // downward wrap from 0 to 7
        cycle(1, 0, 0);
        cycle(0, 1, 3'b000);
        cycle(0, 1, 3'b100);
        check("wrap_dn_wraps", int'(wraps_w), 15);
        check("wrap_dn_dir", int'(dir_w), 0);

        // non-adjacent single-bit change enters fault
        cycle(1, 0, 0);
        cycle(0, 1, 3'b001);
        cycle(0, 1, 3'b101);
        check("fault_err", int'(err_w), 1);
        check("fault_out", int'(out_w), 1);
        cycle(0, 1, 3'b011);
        cycle(0, 1, 3'b000);
        check("fault_frozen", int'(out_w), 1);
        cycle(1, 0, 0);

        // repeat sample and En=0 toggling
        cycle(0, 1, 3'b011);
        cycle(0, 1, 3'b011);
        check("repeat_step", int'(step_w), 0);
        cycle(0, 0, 3'b010);
        cycle(0, 0, 3'b111);
        check("en0_out", int'(out_w), 2);

        // reset wins over En; next En is a fresh reference
        cycle(1, 1, 3'b010);
        check("rst_en_locked", int'(locked_w), 0);
        cycle(0, 1, 3'b010);
        check("fresh_ref_out", int'(out_w), 3);

        // randomized mostly-legal walks with occasional resets and jumps
        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 99);
            if (sel < 40)      g = gray_of((m_out + 1) % M);
            else if (sel < 75) g = gray_of((m_out + M - 1) % M);
            else if (sel < 85) g = gray_of(m_out);
            else               g = $urandom_range(0, M - 1);
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), g);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gray_decoder.md
# gray_decoder

Receive-side counterpart of the team's 3-bit Gray counter. It samples a Gray-coded count on a strobe and converts it back to binary. It tracks step direction and wrap-arounds, and flags any transition that is not a legal single Gray step. It sits wherever a Gray count crosses into this clock domain or is checked against the counter that produced it.

## Interface
- W, 3: Gray/binary code width; W ≥ 2.
- CW, 4: signed wrap-counter width.

- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- En  input  1  sample strobe; GrayIn is consumed only on cycles with En=1.
- GrayIn  input  W  Gray-coded count to decode.
- Output  output  W  binary value of the last accepted code.
- Step  output  1  one-cycle pulse: the last sample moved ±1.
- Dir  output  1  direction of the last step: 1 = up, 0 = down.
- Wraps  output  CW  signed net wrap count, two's complement, modulo 2^CW.
- Overflow  output  1  sticky; set on the first upward wrap from 2^W−1 to 0.
- Error  output  1  sticky; an illegal transition was seen.
- Locked  output  1  a reference sample has been taken and the block is tracking.

## Operation
- Decode is combinational: b[W−1]=g[W−1]; b[i]=b[i+1]^g[i]. The result is nb; the registered previous value is pb.
- Delta d = (nb − pb) mod 2^W, taken at W bits.
- State machine: UNLOCKED, TRACK, FAULT. Reset enters UNLOCKED.
- UNLOCKED, En=1:
  - pb and Output load nb.
  - Go to TRACK; Locked=1.
  - No Step, no wrap accounting.
- TRACK, En=1, d=0: hold everything; Step=0.
- TRACK, En=1, d=1 (up step):
  - Output=nb; Step=1; Dir=1.
  - If pb=2^W−1 and nb=0: Wraps+1 and Overflow←1.
- TRACK, En=1, d=2^W−1 (down step):
  - Output=nb; Step=1; Dir=0.
  - If pb=0 and nb=2^W−1: Wraps−1. Overflow is unaffected.
- TRACK, En=1, any other d:
  - Go to FAULT; Error←1.
  - Output, Dir and Wraps hold their last good values; Step=0.
  - This includes single-bit Gray changes that are not adjacent codes, e.g. 001→101.
- FAULT: all En samples are ignored. Outputs are frozen and Locked stays 1. Only Reset exits FAULT.
- Wraps wraps modulo 2^CW with no saturation and no flag of its own.
- En=0: no state change. Step is 0 on every cycle in which no step was accepted.

## Timing
- All outputs are registered. An En sample at edge k is reflected in the outputs after edge k, so latency is 1 cycle.
- Step is high for exactly one cycle per accepted step. Back-to-back En samples can produce Step on consecutive cycles.
- Reset takes priority over En in the same cycle. After the edge:
  - Output=0, Step=0, Dir=0, Wraps=0, Overflow=0, Error=0, Locked=0.
  - State is UNLOCKED.
- Reset mid-operation behaves the same, including from FAULT. The next En sample is a fresh reference.
- No sticky flag clears without Reset.

## Test plan
- Reset, then En with GrayIn=000,001,011,010,110,111,101,100 on consecutive cycles -> Locked=1 after the first sample. Output then shows 0..7 in order. Step=1 with Dir=1 on each of the last 7 samples. Wraps=0, Overflow=0.
- Continue the previous sequence with GrayIn=000 -> Output=0, Step=1, Dir=1, Wraps=1, Overflow=1. A following 001 gives Output=1 with Overflow still 1.
- Fresh Reset, then GrayIn=000 followed by 100 -> Output=7, Step=1, Dir=0, Wraps=−1 (4'b1111), Overflow=0.
- Locked at 001, then GrayIn=101 -> Error=1, Output stays 1, Step=0. Further legal samples change nothing. Reset gives all outputs 0 and Locked=0.
- Locked at 011 (Output=2), repeat 011 with En=1, then toggle GrayIn with En=0 -> no Step, Output stays 2.
- Assert Reset and En together with GrayIn=010 while tracking -> the reset values win. The next En with 010 gives Output=3, Locked=1, Step=0.
